// File: rtl/rr_mux8_pkg.sv
// rr_mux8 shared types: lane count, lane index and packet-lock state.
// Optional packet lock is enabled with RR_MUX8_PKT_LOCK_EN.
package rr_mux8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] lane_t;

  typedef enum logic {
    ARB,
    LOCKED
  } lock_e;

  function automatic lane_t lane_add(
    input lane_t a,
    input int unsigned k
  );
    return lane_t'(a + lane_t'(k));
  endfunction

endpackage

// File: rtl/rr_mux8_if.sv
// rr_mux8 lane/stream bundle; master drives lanes, slave is the mux.
// RR_MUX8_PKT_LOCK_EN adds in_last/out_last.
interface rr_mux8_if #(
  parameter int DATA_W = 1
);
  import rr_mux8_pkg::*;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  lane_t                    out_sel;
  logic                     out_ready;

`ifdef RR_MUX8_PKT_LOCK_EN
  logic [NUM_CH-1:0]        in_last;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_sel, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_sel, out_last
  );
`else
  modport master (
    output in_valid, in_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid, in_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_data,
    output out_sel
  );
`endif

endinterface

// File: rtl/rr_arb8.sv
// Combinational rotating-priority arbiter over 8 requests.
// Search order is ptr+1 .. ptr+8 (mod 8).
module rr_arb8
  import rr_mux8_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  lane_t             i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output lane_t             o_idx,
  output logic              o_any
);

  lane_t w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_c = lane_add(i_ptr, k);
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_idx      = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux8.sv
// 8-to-1 round-robin collector with one registered output stage.
// RR_MUX8_PKT_LOCK_EN holds the grant on a lane until in_last.
module rr_mux8
  import rr_mux8_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input logic        clk,
  input logic        rst_n,
  rr_mux8_if.slave   bus
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  lane_t             r_sel;
  lane_t             r_ptr;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  lane_t             w_idx;
  logic              w_any;
  logic              w_load;
  logic [DATA_W-1:0] w_lane_data;

  assign w_load = !r_valid || bus.out_ready;

  assign w_lane_data =
    bus.in_data[int'(w_idx)*DATA_W +: DATA_W];

`ifdef RR_MUX8_PKT_LOCK_EN
  lock_e r_state;
  lock_e w_state_nxt;
  lane_t r_lock_ch;
  lane_t w_lock_nxt;
  logic  r_last;
  logic  w_last;
  logic  w_take;

  // While locked only the owning lane may request.
  assign w_req = (r_state == LOCKED)
    ? (bus.in_valid & (NUM_CH'(1) << r_lock_ch))
    : bus.in_valid;

  assign w_last = bus.in_last[w_idx];
  assign w_take = w_load && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    if (w_take) begin
      unique case (r_state)
        ARB: begin
          if (!w_last) begin
            w_state_nxt = LOCKED;
            w_lock_nxt  = w_idx;
          end
        end
        LOCKED: begin
          if (w_last) w_state_nxt = ARB;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
    end else if (w_load && w_any) begin
      r_last <= w_last;
    end
  end

  assign bus.out_last = r_last;
`else
  assign w_req = bus.in_valid;
`endif

  rr_arb8 u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign bus.in_ready =
    (rst_n && w_load) ? w_gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= lane_t'(NUM_CH - 1);
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= w_lane_data;
        r_sel  <= w_idx;
        r_ptr  <= w_idx;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux8.sv
// Testbench for rr_mux8: vector table plus scoreboard of output beats.
// Build with RR_MUX8_PKT_LOCK_EN to exercise packet lock.
module tb_rr_mux8;

  logic clk;
  logic rst_n;

  rr_mux8_if #(.DATA_W(1)) bus ();

  rr_mux8 #(.DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    logic [7:0] d;
    logic       ordy;
    logic [7:0] er;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic       data;
    logic       last;
  } exp_t;

  vec_t tbl [29];
  exp_t sb_q [$];
  logic m_ov;
  int   n_tests;
  int   n_fail;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [2:0] oh2idx(
    input logic [7:0] oh
  );
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic cyc(
    input logic [7:0] v,
    input logic [7:0] d,
    input logic       ordy,
    input logic [7:0] lst,
    input logic [7:0] er
  );
    exp_t e;
    logic [2:0] g;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef RR_MUX8_PKT_LOCK_EN
    bus.in_last   = lst;
`endif
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q[0];
        chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
        chk("out_data", 32'(bus.out_data), 32'(e.data));
`ifdef RR_MUX8_PKT_LOCK_EN
        chk("out_last", 32'(bus.out_last), 32'(e.last));
`endif
        if (ordy) void'(sb_q.pop_front());
      end
    end
    if (er != 8'h00) begin
      g = oh2idx(er);
      e.sel  = g;
      e.data = d[g];
      e.last = lst[g];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!m_ov || ordy) m_ov = (er != 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ov    = 1'b0;

    tbl[0]  = '{8'hFF, 8'h5A, 1'b1, 8'h01};
    tbl[1]  = '{8'hFF, 8'h5A, 1'b1, 8'h02};
    tbl[2]  = '{8'hFF, 8'h5A, 1'b1, 8'h04};
    tbl[3]  = '{8'hFF, 8'hC3, 1'b1, 8'h08};
    tbl[4]  = '{8'hFF, 8'hC3, 1'b1, 8'h10};
    tbl[5]  = '{8'hFF, 8'hC3, 1'b1, 8'h20};
    tbl[6]  = '{8'hFF, 8'hF0, 1'b1, 8'h40};
    tbl[7]  = '{8'hFF, 8'h0F, 1'b1, 8'h80};
    tbl[8]  = '{8'hFF, 8'h01, 1'b1, 8'h01};
    tbl[9]  = '{8'h20, 8'h20, 1'b1, 8'h20};
    tbl[10] = '{8'h20, 8'h20, 1'b1, 8'h20};
    tbl[11] = '{8'h20, 8'h20, 1'b1, 8'h20};
    tbl[12] = '{8'h18, 8'h08, 1'b1, 8'h08};
    tbl[13] = '{8'h18, 8'h08, 1'b0, 8'h00};
    tbl[14] = '{8'h18, 8'h08, 1'b0, 8'h00};
    tbl[15] = '{8'h18, 8'h08, 1'b0, 8'h00};
    tbl[16] = '{8'h18, 8'h08, 1'b0, 8'h00};
    tbl[17] = '{8'h18, 8'h08, 1'b1, 8'h10};
    tbl[18] = '{8'h00, 8'h00, 1'b1, 8'h00};
    tbl[19] = '{8'h00, 8'h00, 1'b1, 8'h00};
    tbl[20] = '{8'h80, 8'h80, 1'b1, 8'h80};
    tbl[21] = '{8'h41, 8'h01, 1'b1, 8'h01};
    tbl[22] = '{8'h40, 8'h40, 1'b1, 8'h40};
    tbl[23] = '{8'h00, 8'h00, 1'b0, 8'h00};
    tbl[24] = '{8'h00, 8'h00, 1'b1, 8'h00};
    tbl[25] = '{8'h00, 8'h00, 1'b0, 8'h00};
    tbl[26] = '{8'h02, 8'h02, 1'b0, 8'h02};
    tbl[27] = '{8'h02, 8'h02, 1'b0, 8'h00};
    tbl[28] = '{8'h00, 8'h00, 1'b1, 8'h00};

    rst_n         = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b1;
`ifdef RR_MUX8_PKT_LOCK_EN
    bus.in_last   = 8'hFF;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef RR_MUX8_PKT_LOCK_EN
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
`endif
    bus.in_valid = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      cyc(tbl[i].v, tbl[i].d, tbl[i].ordy,
          8'hFF, tbl[i].er);

    // Async reset while a beat is pending.
    cyc(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h04);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 8'h00;
    sb_q.delete();
    m_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h01);

`ifdef RR_MUX8_PKT_LOCK_EN
    cyc(8'h14, 8'h04, 1'b1, 8'h00, 8'h04);
    cyc(8'h14, 8'h00, 1'b1, 8'h00, 8'h04);
    cyc(8'h14, 8'h04, 1'b1, 8'h04, 8'h04);
    cyc(8'h10, 8'h10, 1'b1, 8'hFF, 8'h10);
`else
    cyc(8'h14, 8'h04, 1'b1, 8'h00, 8'h04);
    cyc(8'h14, 8'h00, 1'b1, 8'h00, 8'h10);
    cyc(8'h14, 8'h04, 1'b1, 8'h04, 8'h04);
    cyc(8'h10, 8'h10, 1'b1, 8'hFF, 8'h10);
`endif
    cyc(8'h00, 8'h00, 1'b1, 8'hFF, 8'h00);
    cyc(8'h00, 8'h00, 1'b1, 8'hFF, 8'h00);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
